// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - Bus widths, bus layouts and load opcode indices for the memory stage.
package mem_stage_pkg;

    localparam int ES_TO_MS_BUS_WD = 206;
    localparam int MS_TO_WS_BUS_WD = 199;
    localparam int MS_FWD_BUS_WD   = 40;

    localparam int LOAD_B  = 0;
    localparam int LOAD_H  = 1;
    localparam int LOAD_W  = 2;
    localparam int LOAD_BU = 3;
    localparam int LOAD_HU = 4;

    // Field order is MSB to LSB, matching the execute-stage packing.
    typedef struct packed {
        logic        mem_req;
        logic [31:0] vaddr;
        logic [8:0]  csr_esubcode;
        logic        ex;
        logic        ertn;
        logic [31:0] csr_wvalue;
        logic [5:0]  csr_ecode;
        logic        csr_re;
        logic        csr_we;
        logic [13:0] csr_num;
        logic [31:0] csr_wmask;
        logic [4:0]  load_op;
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [31:0] pc;
    } es_to_ms_bus_t;

    typedef struct packed {
        logic [31:0] vaddr;
        logic [8:0]  csr_esubcode;
        logic        ex;
        logic        ertn;
        logic [31:0] csr_wvalue;
        logic [5:0]  csr_ecode;
        logic        csr_re;
        logic        csr_we;
        logic [13:0] csr_num;
        logic [31:0] csr_wmask;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic [31:0] pc;
    } ms_to_ws_bus_t;

endpackage

// File: rtl/mem_stage_load_ext.sv
// rtl/mem_stage_load_ext.sv - Selects the addressed byte/halfword of load data and extends it.
module mem_stage_load_ext
    import mem_stage_pkg::*;
(
    input  logic [4:0]  load_op,
    input  logic [1:0]  vaddr_low,
    input  logic [31:0] rdata,
    output logic [31:0] ext_data
);

    logic [7:0]  byte_data;
    logic [15:0] half_data;

    always_comb begin
        byte_data = rdata[7:0];
        case (vaddr_low)
            2'd0: byte_data = rdata[7:0];
            2'd1: byte_data = rdata[15:8];
            2'd2: byte_data = rdata[23:16];
            2'd3: byte_data = rdata[31:24];
            default: byte_data = rdata[7:0];
        endcase
        half_data = vaddr_low[1] ? rdata[31:16] : rdata[15:0];

        ext_data = rdata;
        if (load_op[LOAD_B])
            ext_data = {{24{byte_data[7]}}, byte_data};
        else if (load_op[LOAD_BU])
            ext_data = {24'd0, byte_data};
        else if (load_op[LOAD_H])
            ext_data = {{16{half_data[15]}}, half_data};
        else if (load_op[LOAD_HU])
            ext_data = {16'd0, half_data};
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - LoongArch memory stage: waits for data-SRAM responses, buffers them, drains stale ones after flush.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    input  logic                       es_mem_req_fire,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic [MS_FWD_BUS_WD-1:0]   ms_fwd_bus,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata,
    input  logic                       ms_flush_pipe,
    output logic                       ms_ex
);

    logic          ms_valid;
    es_to_ms_bus_t ms_bus;
    logic          rdata_buf_valid;
    logic [31:0]   rdata_buf;
    logic [1:0]    discard_cnt;

    logic          data_ok_live;
    logic          ms_ready_go;
    logic          ms_leave;
    logic          buf_set;
    logic          stale_inc;
    logic [2:0]    discard_sum;
    logic [31:0]   load_rdata;
    logic [31:0]   ext_data;
    logic [31:0]   final_result;
    logic          fwd_valid;
    logic          blk_valid;
    ms_to_ws_bus_t ws_bus;

    // A strobe only belongs to the resident instruction once all stale responses are drained.
    assign data_ok_live = data_sram_data_ok && (discard_cnt == 2'd0);
    assign ms_ready_go  = !ms_bus.mem_req || ms_bus.ex || rdata_buf_valid || data_ok_live;
    assign ms_allowin   = !ms_valid || (ms_ready_go && ws_allowin);
    assign ms_leave     = ms_valid && ms_ready_go && ws_allowin;
    assign buf_set      = data_ok_live && ms_valid && ms_bus.mem_req && !(ms_ready_go && ws_allowin);

    assign stale_inc = ms_valid && ms_bus.mem_req && !ms_bus.ex && !rdata_buf_valid && !data_sram_data_ok;

    always_comb begin
        discard_sum = {1'b0, discard_cnt};
        if (ms_flush_pipe)
            discard_sum = discard_sum + {2'b00, stale_inc} + {2'b00, es_mem_req_fire};
        if (data_sram_data_ok && (discard_cnt != 2'd0))
            discard_sum = discard_sum - 3'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid        <= 1'b0;
            rdata_buf_valid <= 1'b0;
            discard_cnt     <= 2'd0;
        end else begin
            if (ms_flush_pipe)
                ms_valid <= 1'b0;
            else if (ms_allowin)
                ms_valid <= es_to_ms_valid;

            if (ms_flush_pipe || ms_leave)
                rdata_buf_valid <= 1'b0;
            else if (buf_set)
                rdata_buf_valid <= 1'b1;

            discard_cnt <= discard_sum[2] ? 2'd3 : discard_sum[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (es_to_ms_valid && ms_allowin)
            ms_bus <= es_to_ms_bus_t'(es_to_ms_bus);
        if (buf_set)
            rdata_buf <= data_sram_rdata;
    end

    assign load_rdata = rdata_buf_valid ? rdata_buf : data_sram_rdata;

    mem_stage_load_ext u_load_ext (
        .load_op   (ms_bus.load_op),
        .vaddr_low (ms_bus.vaddr[1:0]),
        .rdata     (load_rdata),
        .ext_data  (ext_data)
    );

    assign final_result   = ms_bus.res_from_mem ? ext_data : ms_bus.result;
    assign ms_to_ws_valid = ms_valid && ms_ready_go && !ms_flush_pipe;
    assign fwd_valid      = ms_to_ws_valid && ms_bus.gr_we;
    assign blk_valid      = ms_valid && ms_bus.res_from_mem && !ms_ready_go;
    assign ms_ex          = ms_valid && (ms_bus.ex || ms_bus.ertn);

    always_comb begin
        ws_bus.vaddr        = ms_bus.vaddr;
        ws_bus.csr_esubcode = ms_bus.csr_esubcode;
        ws_bus.ex           = ms_bus.ex;
        ws_bus.ertn         = ms_bus.ertn;
        ws_bus.csr_wvalue   = ms_bus.csr_wvalue;
        ws_bus.csr_ecode    = ms_bus.csr_ecode;
        ws_bus.csr_re       = ms_bus.csr_re;
        ws_bus.csr_we       = ms_bus.csr_we;
        ws_bus.csr_num      = ms_bus.csr_num;
        ws_bus.csr_wmask    = ms_bus.csr_wmask;
        ws_bus.gr_we        = ms_bus.gr_we;
        ws_bus.dest         = ms_bus.dest;
        ws_bus.final_result = final_result;
        ws_bus.pc           = ms_bus.pc;
    end

    assign ms_to_ws_bus = ws_bus;
    assign ms_fwd_bus   = {ms_bus.csr_re && ms_valid, fwd_valid, blk_valid, ms_bus.dest, final_result};

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - Directed self-checking bench for mem_stage.
module tb_mem_stage;

    logic         clk;
    logic         reset;
    logic         ws_allowin;
    logic         ms_allowin;
    logic         es_to_ms_valid;
    logic [205:0] es_to_ms_bus;
    logic         es_mem_req_fire;
    logic         ms_to_ws_valid;
    logic [198:0] ms_to_ws_bus;
    logic [39:0]  ms_fwd_bus;
    logic         data_sram_data_ok;
    logic [31:0]  data_sram_rdata;
    logic         ms_flush_pipe;
    logic         ms_ex;

    int checks = 0;
    int errors = 0;

    mem_stage dut (
        .clk               (clk),
        .reset             (reset),
        .ws_allowin        (ws_allowin),
        .ms_allowin        (ms_allowin),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .es_mem_req_fire   (es_mem_req_fire),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .ms_fwd_bus        (ms_fwd_bus),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ms_flush_pipe     (ms_flush_pipe),
        .ms_ex             (ms_ex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [205:0] mk(input logic mem_req, input logic ex, input logic csr_re,
                                        input logic [4:0] load_op, input logic res_from_mem,
                                        input logic gr_we, input logic [4:0] dest,
                                        input logic [31:0] vaddr, input logic [31:0] result,
                                        input logic [31:0] pc);
        logic [205:0] b;
        b = '0;
        b[205]     = mem_req;
        b[204:173] = vaddr;
        b[163]     = ex;
        b[123]     = csr_re;
        b[75:71]   = load_op;
        b[70]      = res_from_mem;
        b[69]      = gr_we;
        b[68:64]   = dest;
        b[63:32]   = result;
        b[31:0]    = pc;
        return b;
    endfunction

    task automatic accept(input logic [205:0] bus, input logic allow);
        es_to_ms_valid    = 1'b1;
        es_to_ms_bus      = bus;
        ws_allowin        = allow;
        data_sram_data_ok = 1'b0;
        tick();
        es_to_ms_valid    = 1'b0;
    endtask

    task automatic load_run(input string tag, input logic [4:0] op, input logic [31:0] vaddr,
                            input logic [31:0] rdata, input logic [31:0] exp);
        accept(mk(1'b1, 1'b0, 1'b0, op, 1'b1, 1'b1, 5'd4, vaddr, 32'h0, 32'h1c00_0000), 1'b1);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = rdata;
        #1;
        check({tag, "_valid"}, ms_to_ws_valid, 1);
        check({tag, "_data"}, ms_to_ws_bus[63:32], exp);
        tick();
        data_sram_data_ok = 1'b0;
    endtask

    initial begin
        reset = 1'b1; ws_allowin = 1'b0; es_to_ms_valid = 1'b0; es_to_ms_bus = '0;
        es_mem_req_fire = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = '0; ms_flush_pipe = 1'b0;
        tick();
        tick();
        check("rst_ws_valid", ms_to_ws_valid, 0);
        check("rst_fwd", ms_fwd_bus, 0);
        check("rst_ex", ms_ex, 0);
        check("rst_allowin", ms_allowin, 1);
        reset = 1'b0;
        tick();

        // Non-memory instruction with csr_re
        accept(mk(1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 5'd3, 32'h0, 32'h1234_5678, 32'h1c00_0040), 1'b1);
        #1;
        check("alu_valid", ms_to_ws_valid, 1);
        check("alu_result", ms_to_ws_bus[63:32], 32'h1234_5678);
        check("alu_pc", ms_to_ws_bus[31:0], 32'h1c00_0040);
        check("alu_fwd_hi", ms_fwd_bus[39:32], {1'b1, 1'b1, 1'b0, 5'd3});
        tick();
        #1;
        check("alu_gone", ms_to_ws_valid, 0);
        tick();

        load_run("ldw", 5'b00100, 32'h0000_1000, 32'h8899_AABB, 32'h8899_AABB);
        #1;
        check("ldw_gone", ms_to_ws_valid, 0);
        load_run("ldb", 5'b00001, 32'h0000_1003, 32'h80FF_0000, 32'hFFFF_FF80);
        load_run("ldbu", 5'b01000, 32'h0000_1003, 32'h80FF_0000, 32'h0000_0080);
        load_run("ldh", 5'b00010, 32'h0000_1000, 32'h1234_8001, 32'hFFFF_8001);
        load_run("ldhu", 5'b10000, 32'h0000_1002, 32'h8001_1234, 32'h0000_8001);

        // Response buffered across a write-back stall
        accept(mk(1'b1, 1'b0, 1'b0, 5'b00100, 1'b1, 1'b1, 5'd6, 32'h2000, 32'h0, 32'h1c00_0100), 1'b0);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hCAFE_F00D;
        #1;
        check("buf_allowin0", ms_allowin, 0);
        tick();
        data_sram_data_ok = 1'b0;
        for (int i = 0; i < 2; i++) begin
            data_sram_rdata = 32'hDEAD_BEEF;
            #1;
            check("buf_hold_allowin", ms_allowin, 0);
            check("buf_hold_data", ms_to_ws_bus[63:32], 32'hCAFE_F00D);
            tick();
        end
        ws_allowin = 1'b1;
        #1;
        check("buf_rel_valid", ms_to_ws_valid, 1);
        check("buf_rel_data", ms_to_ws_bus[63:32], 32'hCAFE_F00D);
        check("buf_rel_allowin", ms_allowin, 1);
        tick();
        #1;
        check("buf_gone", ms_to_ws_valid, 0);
        tick();

        // Forwarding: blocked while waiting, then forwarded with data
        accept(mk(1'b1, 1'b0, 1'b0, 5'b00100, 1'b1, 1'b1, 5'd7, 32'h3000, 32'h0, 32'h1c00_0200), 1'b1);
        #1;
        check("fwd_blk", ms_fwd_bus[39:37], 3'b001);
        tick();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h1122_3344;
        #1;
        check("fwd_out", ms_fwd_bus, {1'b0, 1'b1, 1'b0, 5'd7, 32'h1122_3344});
        tick();
        data_sram_data_ok = 1'b0;

        // Flush with a waiting load plus a request firing in execute: two stale responses
        accept(mk(1'b1, 1'b0, 1'b0, 5'b00100, 1'b1, 1'b1, 5'd8, 32'h4000, 32'h0, 32'h1c00_0300), 1'b1);
        ms_flush_pipe   = 1'b1;
        es_mem_req_fire = 1'b1;
        #1;
        check("fl_valid", ms_to_ws_valid, 0);
        tick();
        ms_flush_pipe   = 1'b0;
        es_mem_req_fire = 1'b0;
        es_to_ms_valid  = 1'b1;
        es_to_ms_bus    = mk(1'b1, 1'b0, 1'b0, 5'b00100, 1'b1, 1'b1, 5'd9, 32'h5000, 32'h0, 32'h1c00_0400);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0000_BAD1;
        #1;
        check("fl_stale1_allowin", ms_allowin, 1);
        tick();
        es_to_ms_valid  = 1'b0;
        data_sram_rdata = 32'h0000_BAD2;
        #1;
        check("fl_stale2_valid", ms_to_ws_valid, 0);
        check("fl_stale2_blk", ms_fwd_bus[37], 1);
        tick();
        data_sram_rdata = 32'h600D_600D;
        #1;
        check("fl_new_valid", ms_to_ws_valid, 1);
        check("fl_new_data", ms_to_ws_bus[63:32], 32'h600D_600D);
        tick();
        data_sram_data_ok = 1'b0;

        // Excepting memory instruction passes without a response and leaves nothing to discard
        accept(mk(1'b1, 1'b1, 1'b0, 5'b00100, 1'b1, 1'b1, 5'd10, 32'h6000, 32'h0, 32'h1c00_0500), 1'b0);
        #1;
        check("ex_ms_ex", ms_ex, 1);
        check("ex_valid", ms_to_ws_valid, 1);
        tick();
        ms_flush_pipe = 1'b1;
        #1;
        check("ex_flush_valid", ms_to_ws_valid, 0);
        tick();
        ms_flush_pipe = 1'b0;
        #1;
        check("ex_after_ms_ex", ms_ex, 0);
        accept(mk(1'b1, 1'b0, 1'b0, 5'b00100, 1'b1, 1'b1, 5'd11, 32'h7000, 32'h0, 32'h1c00_0600), 1'b1);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0BAD_CAFE;
        #1;
        check("ex_next_valid", ms_to_ws_valid, 1);
        check("ex_next_data", ms_to_ws_bus[63:32], 32'h0BAD_CAFE);
        tick();
        data_sram_data_ok = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
